// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: register map, STATUS layout and bus-state type shared by the UART MMIO bridge.
package uart_bridge_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_OVF = 3;
  localparam logic [31:0] RX_EMPTY_VALUE = 32'hFFFF_FFFF;
  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;
  function automatic logic [31:0] status_word(input logic rx_empty, input logic tx_full,
                                              input logic tx_empty, input logic rx_ovf,
                                              input logic [7:0] rx_cnt, input logic [7:0] tx_cnt);
    logic [31:0] s;
    s = '0;
    s[ST_RX_AVAIL] = !rx_empty;
    s[ST_TX_FULL] = tx_full;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_RX_OVF] = rx_ovf;
    s[15:8] = rx_cnt;
    s[23:16] = tx_cnt;
    return s;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte FIFO with registered head output, flush priority and push-on-full when popping.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [CNT_W-1:0] cnt_n;
  logic do_push, do_pop;
  logic [7:0] head_n;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_comb begin
    rd_n = flush ? '0 : rd_ptr + AW'(do_pop);
    cnt_n = flush ? '0 : count + CNT_W'(do_push) - CNT_W'(do_pop);
    // the new head may be the byte being written this very cycle
    head_n = (cnt_n == '0) ? 8'h00 : (do_push && wr_ptr == rd_n) ? data_in : mem[rd_n];
  end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      data_out <= '0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + AW'(do_push);
      rd_ptr <= rd_n;
      count <= cnt_n;
      data_out <= head_n;
    end
endmodule

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: picorv32 native-bus slave exposing DATA/STATUS/CTRL over TX/RX byte FIFOs.
module uart_mmio_bridge
  import uart_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_strobe,
  input  logic [7:0]  rx_data
);
  bus_state_e state, state_n;
  logic [1:0] off;
  logic is_wr, data_push_req, stall, acc;
  logic tx_push, tx_pop, rx_pop, flush, clr_ovf, set_ovf, rx_ovf;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic [7:0] rx_head;
  logic [31:0] rd_val;
  logic unused_bits;
  assign unused_bits = ^{wdata[31:8], addr[1:0]};
  assign off = addr[3:2];
  assign is_wr = |wstrb;
  assign data_push_req = off == REG_DATA && wstrb[0];
  assign tx_pop = tx_valid && tx_ready;
  // a full TX FIFO still takes the write if a byte leaves on the same edge
  assign stall = data_push_req && tx_full && !tx_pop;
  always_comb begin
    state_n = BUS_IDLE;
    acc = 1'b0;
    if (state == BUS_IDLE && sel && !stall) begin
      acc = 1'b1;
      state_n = BUS_ACK;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= BUS_IDLE;
    else state <= state_n;
  assign ready = state == BUS_ACK;
  assign tx_push = acc && data_push_req;
  assign rx_pop = acc && off == REG_DATA && !is_wr;
  assign flush = acc && off == REG_CTRL && is_wr && wdata[1];
  assign clr_ovf = acc && off == REG_CTRL && is_wr && wdata[0];
  assign set_ovf = rx_strobe && rx_full && !rx_pop && !flush;
  assign tx_valid = !tx_empty;
  always_comb
    rd_val = off == REG_DATA ? (rx_empty ? RX_EMPTY_VALUE : {24'h0, rx_head}) :
             off == REG_STATUS ? status_word(rx_empty, tx_full, tx_empty, rx_ovf,
                                             8'(rx_count), 8'(tx_count)) : 32'h0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rdata <= '0;
      rx_ovf <= 1'b0;
    end else begin
      rdata <= acc ? rd_val : 32'h0;
      rx_ovf <= (rx_ovf && !clr_ovf) || set_ovf;
    end
  byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx (
    .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop), .flush(flush),
    .data_in(wdata[7:0]), .data_out(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx (
    .clk(clk), .resetn(resetn), .push(rx_strobe), .pop(rx_pop), .flush(flush),
    .data_in(rx_data), .data_out(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: scoreboard bench for the UART MMIO bridge (bus reads and TX bytes queued as expected).
module tb_uart_mmio_bridge;
  logic clk = 0, resetn = 0, sel = 0, tx_ready = 0, rx_strobe = 0, ready, tx_valid;
  logic [3:0] addr = 0, wstrb = 0;
  logic [31:0] wdata = 0, rdata;
  logic [7:0] rx_data = 0, tx_data;
  int tests = 0, failed = 0;
  logic [31:0] rd_q[$];
  logic [7:0] tx_q[$];

  uart_mmio_bridge #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .rdata(rdata), .ready(ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_strobe(rx_strobe), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic access(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                        input logic sb, input logic [7:0] sd, input string name);
    int lat = 0;
    logic [31:0] exp;
    sel = 1; addr = a; wstrb = s; wdata = d; rx_strobe = sb; rx_data = sd;
    do begin
      @(negedge clk); lat++; rx_strobe = 0;
    end while (!ready && lat < 8);
    tests++;
    if (lat != 1 || ready !== 1'b1) begin
      failed++; $display("FAIL %s latency: got %0d cycles ready=%b, want 1", name, lat, ready);
    end
    if (s == 0 && rd_q.size() > 0) begin
      exp = rd_q.pop_front(); tests++;
      if (rdata !== exp) begin failed++; $display("FAIL %s rdata: got %h want %h", name, rdata, exp); end
    end
    sel = 0; wstrb = 0;
    @(negedge clk); tests++;
    if (ready !== 1'b0) begin failed++; $display("FAIL %s ready width: ready=%b want 0", name, ready); end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    rd_q.push_back(exp);
    access(a, 4'h0, 32'h0, 1'b0, 8'h0, name);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input string name);
    access(a, 4'hF, d, 1'b0, 8'h0, name);
  endtask

  task automatic strobe_rx(input logic [7:0] d);
    rx_strobe = 1; rx_data = d;
    @(negedge clk); rx_strobe = 0;
  endtask

  task automatic drain_tx(input string name);
    logic [7:0] exp;
    tx_ready = 1;
    for (int i = 0; i < 64 && tx_q.size() > 0; i++) begin
      if (tx_valid) begin
        exp = tx_q.pop_front(); tests++;
        if (tx_data !== exp) begin failed++; $display("FAIL %s tx_data: got %h want %h", name, tx_data, exp); end
      end
      @(negedge clk);
    end
    tests++;
    if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
      failed++; $display("FAIL %s drain: %0d bytes left, tx_valid=%b want 0", name, tx_q.size(), tx_valid);
    end
    tx_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk); tests++;
    if (ready !== 0 || tx_valid !== 0 || tx_data !== 8'h0 || rdata !== 32'h0) begin
      failed++; $display("FAIL reset outputs: ready=%b tx_valid=%b tx_data=%h rdata=%h want all 0", ready, tx_valid, tx_data, rdata);
    end
    rd(4'h4, 32'h0000_0004, "reset_status");
    rd(4'h0, 32'hFFFF_FFFF, "reset_data_empty");
  endtask

  task automatic test_tx();
    tx_ready = 0;
    tx_q.push_back(8'h41); wr(4'h0, 32'h41, "tx_w41");
    tx_q.push_back(8'h42); wr(4'h0, 32'h42, "tx_w42");
    rd(4'h4, 32'h0002_0000, "tx_status_cnt2");
    drain_tx("tx_drain");
  endtask

  task automatic test_tx_stall();
    int stray = 0;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(i[7:0]); wr(4'h0, i, "tx_fill");
    end
    rd(4'h4, 32'h0010_0002, "tx_status_full");
    sel = 1; addr = 4'h0; wstrb = 4'hF; wdata = 32'h99; tx_q.push_back(8'h99);
    repeat (20) begin @(negedge clk); if (ready) stray++; end
    tests++;
    if (stray != 0) begin failed++; $display("FAIL tx_stall: ready seen %0d cycles want 0", stray); end
    tx_ready = 1;
    exp = tx_q.pop_front(); tests++;
    if (tx_valid !== 1'b1 || tx_data !== exp) begin
      failed++; $display("FAIL tx_stall head: tx_valid=%b tx_data=%h want 1/%h", tx_valid, tx_data, exp);
    end
    @(negedge clk); tx_ready = 0; tests++;
    if (ready !== 1'b1) begin failed++; $display("FAIL tx_stall release: ready=%b want 1", ready); end
    sel = 0; wstrb = 0;
    @(negedge clk); tests++;
    if (ready !== 1'b0) begin failed++; $display("FAIL tx_stall ready width: ready=%b want 0", ready); end
    rd(4'h4, 32'h0010_0002, "tx_status_still16");
    drain_tx("tx_stall_drain");
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < 17; i++) strobe_rx(i[7:0]);
    rd(4'h4, 32'h0000_100D, "rx_status_ovf");
    for (int i = 0; i < 16; i++) rd(4'h0, i, "rx_read");
    rd(4'h0, 32'hFFFF_FFFF, "rx_read_empty");
    wr(4'h8, 32'h1, "ctrl_clr_ovf");
    rd(4'h4, 32'h0000_0004, "rx_status_cleared");
  endtask

  task automatic test_rx_pop_full();
    for (int i = 0; i < 16; i++) strobe_rx(8'h20 + i[7:0]);
    rd_q.push_back(32'h20);
    access(4'h0, 4'h0, 32'h0, 1'b1, 8'h55, "rx_pop_full_strobe");
    rd(4'h4, 32'h0000_1005, "rx_status_no_ovf");
    for (int i = 1; i < 16; i++) rd(4'h0, 32'h20 + i, "rx_read_full");
    rd(4'h0, 32'h55, "rx_read_55");
    rd(4'h0, 32'hFFFF_FFFF, "rx_read_empty2");
  endtask

  task automatic test_misc();
    rd(4'h8, 32'h0, "ctrl_read");
    rd(4'hC, 32'h0, "reserved_read");
    wr(4'h4, 32'hFFFF_FFFF, "status_write_ignored");
    wr(4'hC, 32'hFFFF_FFFF, "reserved_write");
    access(4'h0, 4'b0010, 32'h77, 1'b0, 8'h0, "data_write_no_b0");
    rd(4'h4, 32'h0000_0004, "misc_status");
    rd_q.push_back(32'hFFFF_FFFF);
    access(4'h0, 4'h0, 32'h0, 1'b1, 8'h66, "rx_empty_read_strobe");
    rd(4'h0, 32'h66, "rx_read_66");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) wr(4'h0, 32'hA0 + i, "flush_txfill");
    for (int i = 0; i < 3; i++) strobe_rx(8'hB0 + i[7:0]);
    rd(4'h4, 32'h0003_0301, "pre_flush_status");
    access(4'h8, 4'hF, 32'h2, 1'b1, 8'h77, "ctrl_flush");
    rd(4'h4, 32'h0000_0004, "post_flush_status");
    rd(4'h0, 32'hFFFF_FFFF, "post_flush_data");
    tests++;
    if (tx_valid !== 1'b0) begin failed++; $display("FAIL flush tx_valid: got %b want 0", tx_valid); end
  endtask

  task automatic test_reset_mid();
    sel = 1; addr = 4'h0; wstrb = 4'hF; wdata = 32'h5A;
    @(posedge clk); #1;
    resetn = 0; sel = 0; wstrb = 0;
    #1; tests++;
    if (ready !== 1'b0 || tx_valid !== 1'b0) begin
      failed++; $display("FAIL reset_mid: ready=%b tx_valid=%b want 0/0", ready, tx_valid);
    end
    @(negedge clk); resetn = 1;
    @(negedge clk);
    rd(4'h4, 32'h0000_0004, "reset_mid_status");
  endtask

  initial begin
    test_reset();
    test_tx();
    test_tx_stall();
    test_rx_overflow();
    test_rx_pop_full();
    test_misc();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
